// File: rtl/bcd_sub_serial_if.sv
// Start/busy/done request bundle for the digit-serial BCD subtractor.
// Handshake: start is sampled only while busy=0; busy stays high until the done cycle, and done is a one-cycle pulse.
interface bcd_sub_serial_if #(
  parameter int DIGITS = 4
) ();
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  borrow;
  logic                  neg;
  logic                  invalid;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, neg, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, neg, invalid
  );
endinterface

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor, least significant digit first, one digit per clock.
// Define BCD_SUB_MAGNITUDE_EN to add a COMP pass that turns negative results into |a-b|.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_sub_serial_if.slave     bus,
  output logic [1:0]          dbg_state_o
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
`ifdef BCD_SUB_MAGNITUDE_EN
    COMP = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            bw_q, bw_d;
  logic            borrow_q, borrow_d;
  logic            invalid_q, invalid_d;

  logic [3:0]      a_dig, b_dig, d_dig;
  logic [4:0]      t;
  logic            last;
`ifdef BCD_SUB_MAGNITUDE_EN
  logic [3:0]      u;
`endif

  function automatic logic digits_ok(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    idx_d     = idx_q;
    bw_d      = bw_q;
    borrow_d  = borrow_q;
    invalid_d = invalid_q;

    a_dig = a_q[idx_q*4 +: 4];
    b_dig = b_q[idx_q*4 +: 4];
    d_dig = diff_q[idx_q*4 +: 4];
    t     = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, bw_q};
    last  = (idx_q == IW'(DIGITS - 1));
`ifdef BCD_SUB_MAGNITUDE_EN
    u     = 4'd9 - d_dig + {3'b000, bw_q};
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d       = bus.a;
          b_d       = bus.b;
          diff_d    = '0;
          borrow_d  = 1'b0;
          invalid_d = 1'b0;
          idx_d     = '0;
          bw_d      = 1'b0;
          if (digits_ok(bus.a) && digits_ok(bus.b)) begin
            state_d = SUB;
          end else begin
            invalid_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      SUB: begin
        // t[4] is the sign of the 5-bit difference; a negative digit wraps by +10.
        diff_d[idx_q*4 +: 4] = t[4] ? (t[3:0] + 4'd10) : t[3:0];
        bw_d = t[4];
        if (last) begin
          borrow_d = t[4];
          idx_d    = '0;
`ifdef BCD_SUB_MAGNITUDE_EN
          state_d  = t[4] ? COMP : DONE;
`else
          state_d  = DONE;
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
`ifdef BCD_SUB_MAGNITUDE_EN
      // bw_q is 1 on entry here, so it doubles as the initial correction carry.
      COMP: begin
        diff_d[idx_q*4 +: 4] = (u == 4'd10) ? 4'd0 : u;
        bw_d = (u == 4'd10);
        if (last) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      idx_q     <= '0;
      bw_q      <= 1'b0;
      borrow_q  <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      diff_q    <= diff_d;
      idx_q     <= idx_d;
      bw_q      <= bw_d;
      borrow_q  <= borrow_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.diff    = diff_q;
  assign bus.borrow  = borrow_q;
  assign bus.neg     = borrow_q;
  assign bus.invalid = invalid_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_bcd_sub_serial.sv
// Bench for bcd_sub_serial (DIGITS=4): directed cases, handshake/reset scenarios and random operands
// checked against an integer-arithmetic reference model.
module tb_bcd_sub_serial;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc;
  int         n_checks;
  int         n_errors;
  logic [W-1:0] exp_q[$];

  bcd_sub_serial_if #(.DIGITS(DIGITS)) bus ();

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // reference model: plain decimal integer arithmetic
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad_digit(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                           output logic [W-1:0] ed, output bit eb, output bit ei, output int elat);
    int ai, bi, modv;
    modv = 10 ** DIGITS;
    ei = has_bad_digit(av) || has_bad_digit(bv);
    if (ei) begin
      ed = '0; eb = 1'b0; elat = 1;
    end else begin
      ai = bcd2int(av);
      bi = bcd2int(bv);
      eb = (ai < bi);
      elat = DIGITS + 1;
`ifdef BCD_SUB_MAGNITUDE_EN
      ed = int2bcd(eb ? bi - ai : ai - bi);
      if (eb) elat = 2 * DIGITS + 1;
`else
      ed = int2bcd((ai - bi + modv) % modv);
`endif
    end
  endtask

  // driver: one operation, optionally re-pulsing start while busy
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit poke);
    logic [W-1:0] ed;
    bit eb, ei;
    int elat, lat, bcnt;
    ref_model(av, bv, ed, eb, ei, elat);
    exp_q.push_back(ed);
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom);
    lat = 1; bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      bus.start = poke && (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    if (bus.busy) bcnt++;
    check("done_seen", bus.done, 1'b1);
    check("latency", lat, elat);
    check("busy_cycles", bcnt, elat);
    check("diff", bus.diff, exp_q.pop_front());
    check("borrow", bus.borrow, eb);
    check("neg", bus.neg, eb);
    check("invalid", bus.invalid, ei);
    @(posedge clk); #1;
    check("done_pulse_end", bus.done, 1'b0);
    check("busy_after_done", bus.busy, 1'b0);
    check("diff_hold", bus.diff, ed);
  endtask

  task automatic wait_done(output int at);
    int k = 0;
    @(posedge clk); #1;
    while (!bus.done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("held_done_seen", bus.done, 1'b1);
    at = cyc;
  endtask

  initial begin
    int t0, t1, t2;
    bit seen;
    logic [W-1:0] ra, rb, ed;
    bit eb, ei;
    int elat;

    n_checks = 0; n_errors = 0;
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_diff", bus.diff, '0);
    check("rst_borrow", bus.borrow, 1'b0);
    check("rst_neg", bus.neg, 1'b0);
    check("rst_invalid", bus.invalid, 1'b0);
    @(negedge clk) rst = 1'b0;

    // directed cases
    do_op(16'h1234, 16'h0567, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0);
    do_op(16'h0100, 16'h0250, 1'b0);
    do_op(16'h5000, 16'h5000, 1'b0);
    do_op(16'h1000, 16'h0001, 1'b0);
    do_op(16'h12A4, 16'h0001, 1'b0);
    do_op(16'h9999, 16'h0000, 1'b0);
    do_op(16'h0000, 16'h9999, 1'b0);
    do_op(16'h1234, 16'h0567, 1'b1);
    do_op(16'h0000, 16'h0001, 1'b1);

    // start held high: a new operation on the cycle after each done
    ref_model(16'h4321, 16'h1234, ed, eb, ei, elat);
    @(negedge clk);
    bus.a = 16'h4321; bus.b = 16'h1234; bus.start = 1'b1;
    wait_done(t0);
    check("held_diff0", bus.diff, ed);
    wait_done(t1);
    check("held_diff1", bus.diff, ed);
    wait_done(t2);
    bus.start = 1'b0;
    check("held_diff2", bus.diff, ed);
    check("held_spacing1", t1 - t0, DIGITS + 2);
    check("held_spacing2", t2 - t1, DIGITS + 2);
    repeat (3) @(posedge clk);
    #1;
    check("held_idle", bus.busy, 1'b0);

    // reset in the 3rd SUB cycle
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h0567; bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_diff", bus.diff, '0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    check("midrst_no_done", seen, 1'b0);
    do_op(16'h0100, 16'h0250, 1'b0);

    // rst and start on the same edge: reset wins
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0003;
    @(posedge clk); #1;
    check("rst_start_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    check("rst_start_idle", bus.busy, 1'b0);

    // random operands, occasionally with an out-of-range digit
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 9) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      do_op(ra, rb, 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
